mem_arbiter_ctrl: RTL and testbench
===================================

Name: mem_arbiter_ctrl

Overview:
- Parametrised memory controller that arbitrates between the instruction-fetch port and the data-memory port of the pipelined core.
- Serialises each 32-bit word access into BUS_W-bit beats on a single narrow external memory bus, with pipelined reads of fixed latency.
- Replaces direct ROM/RAM wiring so that IF and ME share one memory. Requesters stall on their own until the done pulse.

Parameters:
- ADDR_W, 32: address width on both request ports and on the memory bus.
- BUS_W, 8: external data width; legal values 8, 16, 32. Beats per word N = 32/BUS_W.
- READ_LAT, 1: memory read latency in cycles (1..4). Read data for the address presented in cycle c is valid in cycle c+READ_LAT.
- RR_EN, 0: 0 = ME always wins a tie; 1 = round-robin on tie.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req_i  in  1  instruction fetch request (level).
- if_addr_i  in  ADDR_W  fetch address; bits [1:0] ignored.
- if_data_o  out  32  fetched word; valid while if_done_o=1.
- if_done_o  out  1  one-cycle completion pulse.
- me_req_i  in  1  data request (level).
- me_we_i  in  1  1 = write, 0 = read.
- me_sel_i  in  4  byte enables for writes; byte i = bits [8i+7:8i].
- me_addr_i  in  ADDR_W  data address; bits [1:0] ignored.
- me_wdata_i  in  32  write data.
- me_rdata_o  out  32  read word; valid while me_done_o=1.
- me_done_o  out  1  one-cycle completion pulse.
- mem_ce_o  out  1  memory access enable for this beat.
- mem_we_o  out  1  write strobe for this beat.
- mem_sel_o  out  BUS_W/8  byte enables for this beat.
- mem_addr_o  out  ADDR_W  beat byte address.
- mem_wdata_o  out  BUS_W  beat write data.
- mem_rdata_i  in  BUS_W  beat read data.
- busy_o  out  1  high when state!=IDLE; feeds stall control.

Behaviour:
- Reset: state=IDLE. All outputs 0, including data outputs. Round-robin pointer = IF, so ME wins the first tie.
- States are IDLE, RD, WR, DONE.
- IDLE arbitration:
  - On each edge, sample the requests. If only one is high, grant it. If both are high: ME wins when RR_EN=0; when RR_EN=1, the port not granted last wins.
  - IF requests are always reads.
  - At grant, latch word base {addr[ADDR_W-1:2],2'b00}, we, sel and wdata. Move to RD or WR. Requester inputs are ignored afterwards.
- Beat mapping:
  - Beat k (0..N-1) has address base + k*(BUS_W/8).
  - Beat k carries word bits [k*BUS_W +: BUS_W] (little-endian).
  - mem_sel_o for beat k = sel bits [k*BUS_W/8 +: BUS_W/8].
- RD:
  - Issue beat k in cycle k+1 after grant: mem_ce_o=1, mem_we_o=0, mem_sel_o=all ones.
  - Capture mem_rdata_i READ_LAT cycles after each beat's issue into the beat's slice of an assembly register.
  - After the last capture, enter DONE. The read done pulse is in cycle N+READ_LAT+1 after grant.
- WR:
  - Beats occupy cycles 1..N after grant.
  - mem_ce_o=mem_we_o=1 only if the beat's sel slice is nonzero; otherwise both are 0 for that cycle.
  - Enter DONE after beat N-1. The write done pulse is in cycle N+1.
  - sel=0 completes with no memory writes.
- DONE (one cycle):
  - Assert the granted port's done. For reads, drive the assembled word on its data output.
  - Update the round-robin pointer. Requests are not sampled. Return to IDLE.
- Requester rule: a requester holds req high until its done and drives it to its next value from the cycle after done. The next grant is therefore 2 cycles after DONE at the earliest (DONE, then IDLE sampling).
- Outside RD/WR beats: mem_ce_o=mem_we_o=0, mem_sel_o=0. mem_addr_o/mem_wdata_o hold their last value.
- busy_o = (state!=IDLE).
- Req deasserted mid-operation: the operation completes and done still pulses.
- Reset mid-operation: return to IDLE immediately with all outputs 0. No done is issued. A partially written word stays in memory.
- BUS_W=32: N=1, identical flow.

Test Plan:
- Fetch (BUS_W=8, READ_LAT=1): IF read of 0x100, memory bytes 0x13,0x05,0x00,0x00 at 0x100..0x103 -> mem_addr_o 0x100..0x103 in cycles 1-4; if_done_o in cycle 6 with if_data_o=0x00000513.
- Byte store: ME write 0x204, sel=4'b0100, wdata=0x00AB0000 -> only beat 2 (addr 0x206) has mem_we_o=1 with data 0xAB; me_done_o in cycle 5.
- Tie: if_req_i and me_req_i both high in IDLE with RR_EN=0 -> ME served first, IF second. Repeat with RR_EN=1 -> the grant order alternates across successive ties.
- BUS_W=16, READ_LAT=3: ME read of 0x40 with halves 0xBEEF@0x40 and 0xDEAD@0x42 -> me_rdata_o=0xDEADBEEF; done in cycle 6.
- Reset asserted in cycle 2 of a write -> all outputs 0 asynchronously; no done pulse; the next request is granted normally after reset release.
- Write with sel=0 -> no mem_we_o pulse; me_done_o in cycle N+1.

Source files
------------

// File: rtl/mem_arbiter_ctrl.sv
// Shares one narrow external memory bus between the IF and ME ports of the core.
// Each 32-bit word access is split into BUS_W-bit beats; reads are pipelined with a fixed latency.
module mem_arbiter_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int BUS_W    = 8,
  parameter int READ_LAT = 1,
  parameter int RR_EN    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [31:0]       if_data_o,
  output logic              if_done_o,
  input  logic              me_req_i,
  input  logic              me_we_i,
  input  logic [3:0]        me_sel_i,
  input  logic [ADDR_W-1:0] me_addr_i,
  input  logic [31:0]       me_wdata_i,
  output logic [31:0]       me_rdata_o,
  output logic              me_done_o,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [BUS_W/8-1:0] mem_sel_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [BUS_W-1:0]  mem_wdata_o,
  input  logic [BUS_W-1:0]  mem_rdata_i,
  output logic              busy_o
);

  localparam int N     = 32 / BUS_W;
  localparam int SEL_W = BUS_W / 8;
  localparam int BSH   = $clog2(SEL_W);
  localparam logic [31:0] BEAT_MASK = 32'((64'd1 << BUS_W) - 64'd1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t              state;
  logic                gnt_me;
  logic                last_me;
  logic [ADDR_W-1:0]   base_q;
  logic [3:0]          sel_q;
  logic [31:0]         wdata_q;
  logic [31:0]         asm_q;
  logic [2:0]          beat;
  logic [1:0]          cap;
  logic [READ_LAT-1:0] rd_vld;

  logic                pick_me;
  logic                issue_more;
  logic [ADDR_W-1:0]   grant_base;
  logic [ADDR_W-1:0]   beat_addr;
  logic [BUS_W-1:0]    beat_wdata;
  logic [SEL_W-1:0]    beat_sel;
  logic [31:0]         asm_next;
  logic                unused_addr_lsbs;

  assign unused_addr_lsbs = ^{if_addr_i[1:0], me_addr_i[1:0]};
  assign busy_o = (state != IDLE);

  // last_me remembers the previous grant so a tie under round-robin goes to the other port
  always_comb begin
    pick_me    = me_req_i && (!if_req_i || (RR_EN == 0) || !last_me);
    grant_base = pick_me ? {me_addr_i[ADDR_W-1:2], 2'b00} : {if_addr_i[ADDR_W-1:2], 2'b00};
    issue_more = (beat != 3'(N));
    beat_addr  = base_q + (ADDR_W'(beat) << BSH);
    beat_wdata = BUS_W'(wdata_q >> (BUS_W * int'(beat[1:0])));
    beat_sel   = SEL_W'(sel_q >> (SEL_W * int'(beat[1:0])));
    asm_next   = (asm_q & ~(BEAT_MASK << (BUS_W * int'(cap))))
               | (32'(mem_rdata_i) << (BUS_W * int'(cap)));
  end

  // Beat 0 is driven straight from the request inputs at the grant edge so it lands in cycle 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      gnt_me      <= 1'b0;
      last_me     <= 1'b0;
      base_q      <= '0;
      sel_q       <= '0;
      wdata_q     <= '0;
      asm_q       <= '0;
      beat        <= '0;
      cap         <= '0;
      rd_vld      <= '0;
      if_data_o   <= '0;
      if_done_o   <= 1'b0;
      me_rdata_o  <= '0;
      me_done_o   <= 1'b0;
      mem_ce_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_sel_o   <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      rd_vld <= READ_LAT'({rd_vld, mem_ce_o & ~mem_we_o});
      case (state)
        IDLE: begin
          if (if_req_i || me_req_i) begin
            gnt_me     <= pick_me;
            base_q     <= grant_base;
            beat       <= 3'd1;
            cap        <= 2'd0;
            mem_addr_o <= grant_base;
            if (pick_me && me_we_i) begin
              state       <= WR;
              sel_q       <= me_sel_i;
              wdata_q     <= me_wdata_i;
              mem_ce_o    <= |me_sel_i[SEL_W-1:0];
              mem_we_o    <= |me_sel_i[SEL_W-1:0];
              mem_sel_o   <= me_sel_i[SEL_W-1:0];
              mem_wdata_o <= me_wdata_i[BUS_W-1:0];
            end else begin
              state     <= RD;
              mem_ce_o  <= 1'b1;
              mem_we_o  <= 1'b0;
              mem_sel_o <= '1;
            end
          end
        end
        RD: begin
          if (issue_more) begin
            mem_addr_o <= beat_addr;
            mem_ce_o   <= 1'b1;
            mem_sel_o  <= '1;
            beat       <= beat + 3'd1;
          end else begin
            mem_ce_o  <= 1'b0;
            mem_sel_o <= '0;
          end
          // Captures trail issues by READ_LAT cycles; the last capture completes the word
          if (rd_vld[READ_LAT-1]) begin
            asm_q <= asm_next;
            cap   <= cap + 2'd1;
            if (cap == 2'(N - 1)) begin
              state <= DONE;
              if (gnt_me) begin
                me_done_o  <= 1'b1;
                me_rdata_o <= asm_next;
              end else begin
                if_done_o <= 1'b1;
                if_data_o <= asm_next;
              end
            end
          end
        end
        WR: begin
          if (issue_more) begin
            mem_addr_o  <= beat_addr;
            mem_wdata_o <= beat_wdata;
            mem_sel_o   <= beat_sel;
            mem_ce_o    <= |beat_sel;
            mem_we_o    <= |beat_sel;
            beat        <= beat + 3'd1;
          end else begin
            mem_ce_o  <= 1'b0;
            mem_we_o  <= 1'b0;
            mem_sel_o <= '0;
            state     <= DONE;
            me_done_o <= 1'b1;
          end
        end
        DONE: begin
          if_done_o <= 1'b0;
          me_done_o <= 1'b0;
          last_me   <= gnt_me;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Scoreboard bench for mem_arbiter_ctrl: instance A is BUS_W=8/READ_LAT=1/fixed priority,
// instance B is BUS_W=16/READ_LAT=3/round-robin. Each has a byte-array memory model behind it.
module tb_mem_arbiter_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic preload;
  always #5 clk = ~clk;

  logic        if_req [2];
  logic        me_req [2];
  logic        me_we [2];
  logic [3:0]  me_sel [2];
  logic [31:0] if_addr [2];
  logic [31:0] me_addr [2];
  logic [31:0] me_wdata [2];
  logic [31:0] if_data [2];
  logic [31:0] me_rdata [2];
  logic        if_done [2];
  logic        me_done [2];
  logic        mce [2];
  logic        mwe [2];
  logic        busy [2];
  logic [31:0] maddr [2];
  logic [3:0]  msel [2];
  logic [31:0] mw [2];
  logic [31:0] mrd [2];

  logic [7:0]  a_wdata, a_rdata;
  logic [0:0]  a_sel;
  logic [15:0] b_wdata, b_rdata;
  logic [1:0]  b_sel;

  assign mw[0]   = 32'(a_wdata);
  assign mw[1]   = 32'(b_wdata);
  assign msel[0] = 4'(a_sel);
  assign msel[1] = 4'(b_sel);
  assign a_rdata = mrd[0][7:0];
  assign b_rdata = mrd[1][15:0];

  mem_arbiter_ctrl #(.ADDR_W(32), .BUS_W(8), .READ_LAT(1), .RR_EN(0)) u_dut_a (
    .clk(clk), .rst(rst),
    .if_req_i(if_req[0]), .if_addr_i(if_addr[0]), .if_data_o(if_data[0]), .if_done_o(if_done[0]),
    .me_req_i(me_req[0]), .me_we_i(me_we[0]), .me_sel_i(me_sel[0]), .me_addr_i(me_addr[0]),
    .me_wdata_i(me_wdata[0]), .me_rdata_o(me_rdata[0]), .me_done_o(me_done[0]),
    .mem_ce_o(mce[0]), .mem_we_o(mwe[0]), .mem_sel_o(a_sel), .mem_addr_o(maddr[0]),
    .mem_wdata_o(a_wdata), .mem_rdata_i(a_rdata), .busy_o(busy[0])
  );

  mem_arbiter_ctrl #(.ADDR_W(32), .BUS_W(16), .READ_LAT(3), .RR_EN(1)) u_dut_b (
    .clk(clk), .rst(rst),
    .if_req_i(if_req[1]), .if_addr_i(if_addr[1]), .if_data_o(if_data[1]), .if_done_o(if_done[1]),
    .me_req_i(me_req[1]), .me_we_i(me_we[1]), .me_sel_i(me_sel[1]), .me_addr_i(me_addr[1]),
    .me_wdata_i(me_wdata[1]), .me_rdata_o(me_rdata[1]), .me_done_o(me_done[1]),
    .mem_ce_o(mce[1]), .mem_we_o(mwe[1]), .mem_sel_o(b_sel), .mem_addr_o(maddr[1]),
    .mem_wdata_o(b_wdata), .mem_rdata_i(b_rdata), .busy_o(busy[1])
  );

  logic [7:0] mem [2][1024];

  // Byte-addressed memories: writes land at the edge, read data appears LAT cycles after issue
  for (genvar g = 0; g < 2; g++) begin : g_mem
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] pipe [1:4];
    always @(posedge clk) begin
      int ra;
      ra = int'(maddr[g][9:0]);
      if (preload) begin
        for (int i = 0; i < 1024; i++) mem[g][i] <= 8'h00;
        if (g == 0) begin
          mem[g][256] <= 8'h13;
          mem[g][257] <= 8'h05;
        end else begin
          mem[g][64]  <= 8'hEF;
          mem[g][65]  <= 8'hBE;
          mem[g][66]  <= 8'hAD;
          mem[g][67]  <= 8'hDE;
          mem[g][128] <= 8'h78;
          mem[g][129] <= 8'h56;
          mem[g][130] <= 8'h34;
          mem[g][131] <= 8'h12;
        end
      end else if (mce[g] && mwe[g]) begin
        for (int b = 0; b < 4; b++)
          if (msel[g][b]) mem[g][(ra + b) & 1023] <= mw[g][8*b +: 8];
      end
      pipe[1] <= {mem[g][(ra + 3) & 1023], mem[g][(ra + 2) & 1023],
                  mem[g][(ra + 1) & 1023], mem[g][ra]};
      for (int k = 2; k <= 4; k++) pipe[k] <= pipe[k-1];
    end
    assign mrd[g] = pipe[LAT];
  end

  typedef struct {
    int          dut;
    bit          is_me;
    bit          chk;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int c0 = 0;

  logic [31:0] bl_addr [2][256];
  logic [31:0] bl_data [2][256];
  bit          bl_we [2][256];
  int          bl_cyc [2][256];
  int          bl_n [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: logs every enabled beat and checks each done pulse against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    int idx;
    for (int g = 0; g < 2; g++) begin
      if (mce[g] && !rst) begin
        idx = bl_n[g] & 255;
        bl_addr[g][idx] = maddr[g];
        bl_data[g][idx] = mw[g];
        bl_we[g][idx]   = mwe[g];
        bl_cyc[g][idx]  = cyc;
        bl_n[g]         = bl_n[g] + 1;
      end
      if (if_done[g] || me_done[g]) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL spurious_done: dut %0d pulsed done with nothing expected (cycle %0d)", g, cyc);
        end else begin
          e = exp_q.pop_front();
          checkOutput("done_dut", 64'(g), 64'(e.dut));
          checkOutput("done_port", {62'd0, me_done[g], if_done[g]}, e.is_me ? 64'd2 : 64'd1);
          checkOutput("done_cycle", 64'(cyc), 64'(e.cyc));
          if (e.chk) checkOutput("done_rdata", e.is_me ? me_rdata[g] : if_data[g], e.data);
        end
      end
    end
  end

  task automatic applyStimulus(input int d, input bit rif, input bit rme, input bit we,
                               input logic [3:0] sel, input logic [31:0] ia,
                               input logic [31:0] ma, input logic [31:0] wd);
    @(negedge clk);
    if_addr[d]  = ia;
    me_addr[d]  = ma;
    me_we[d]    = we;
    me_sel[d]   = sel;
    me_wdata[d] = wd;
    if_req[d]   = rif;
    me_req[d]   = rme;
    c0          = cyc;
  endtask

  task automatic expectDone(input int d, input bit is_me, input bit chk,
                            input logic [31:0] data, input int rel);
    exp_t e;
    e.dut = d; e.is_me = is_me; e.chk = chk; e.data = data; e.cyc = c0 + rel;
    exp_q.push_back(e);
  endtask

  // Requesters drop their request once they see their own done
  task automatic waitDone(input int d);
    for (int i = 0; i < 40 && (if_req[d] || me_req[d]); i++) begin
      @(negedge clk);
      if (if_done[d]) if_req[d] = 1'b0;
      if (me_done[d]) me_req[d] = 1'b0;
    end
    if (if_req[d] || me_req[d]) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL done_timeout: dut %0d if_req=%0b me_req=%0b still waiting", d, if_req[d], me_req[d]);
      if_req[d] = 1'b0;
      me_req[d] = 1'b0;
    end
  endtask

  task automatic checkIdleOutputs(input string name, input int d);
    checkOutput({name, "_ctrl"}, {58'd0, busy[d], mce[d], mwe[d], if_done[d], me_done[d], |msel[d]}, 64'd0);
    checkOutput({name, "_bus"}, {maddr[d], mw[d]}, 64'd0);
    checkOutput({name, "_data"}, {if_data[d], me_rdata[d]}, 64'd0);
  endtask

  initial begin
    int s;
    rst = 1'b1;
    preload = 1'b1;
    bl_n[0] = 0;
    bl_n[1] = 0;
    for (int d = 0; d < 2; d++) begin
      if_req[d] = 1'b0; me_req[d] = 1'b0; me_we[d] = 1'b0; me_sel[d] = 4'h0;
      if_addr[d] = '0; me_addr[d] = '0; me_wdata[d] = '0;
    end
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset_a", 0);
    checkIdleOutputs("reset_b", 1);
    rst = 1'b0;
    preload = 1'b0;
    @(negedge clk);

    // A: fetch of 0x100 over four byte beats
    s = bl_n[0];
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h100, 32'h0, 32'h0);
    expectDone(0, 1'b0, 1'b1, 32'h0000_0513, 6);
    waitDone(0);
    checkOutput("fetch_beats", 64'(bl_n[0] - s), 64'd4);
    for (int k = 0; k < 4; k++) begin
      checkOutput("fetch_addr", bl_addr[0][(s + k) & 255], 64'(32'h100 + k));
      checkOutput("fetch_cycle", 64'(bl_cyc[0][(s + k) & 255]), 64'(c0 + 1 + k));
    end

    // A: byte store into lane 2 of word 0x204
    s = bl_n[0];
    applyStimulus(0, 1'b0, 1'b1, 1'b1, 4'b0100, 32'h0, 32'h204, 32'h00AB_0000);
    expectDone(0, 1'b1, 1'b0, 32'h0, 5);
    waitDone(0);
    checkOutput("bstore_beats", 64'(bl_n[0] - s), 64'd1);
    checkOutput("bstore_addr", bl_addr[0][s & 255], 64'h206);
    checkOutput("bstore_we_data", {bl_we[0][s & 255], bl_data[0][s & 255]}, {31'd0, 1'b1, 32'h0000_00AB});
    checkOutput("bstore_cycle", 64'(bl_cyc[0][s & 255]), 64'(c0 + 3));
    checkOutput("bstore_mem", {mem[0][517], mem[0][518], mem[0][519]}, 64'h00_AB_00);

    // A: read back with low address bits set; they must be ignored
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h206, 32'h0);
    expectDone(0, 1'b1, 1'b1, 32'h00AB_0000, 6);
    waitDone(0);

    // A: tie with fixed priority, ME wins even though ME was granted last
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h100, 32'h204, 32'h0);
    expectDone(0, 1'b1, 1'b1, 32'h00AB_0000, 6);
    expectDone(0, 1'b0, 1'b1, 32'h0000_0513, 13);
    waitDone(0);

    // A: write with no byte enables touches nothing
    s = bl_n[0];
    applyStimulus(0, 1'b0, 1'b1, 1'b1, 4'b0000, 32'h0, 32'h300, 32'hFFFF_FFFF);
    expectDone(0, 1'b1, 1'b0, 32'h0, 5);
    waitDone(0);
    checkOutput("sel0_beats", 64'(bl_n[0] - s), 64'd0);
    checkOutput("sel0_mem", {mem[0][768], mem[0][769], mem[0][770], mem[0][771]}, 64'd0);

    // A: reset in cycle 2 of a full-word write
    applyStimulus(0, 1'b0, 1'b1, 1'b1, 4'hF, 32'h0, 32'h208, 32'hA5A5_A5A5);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkIdleOutputs("midreset_a", 0);
    me_req[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset_mem", {mem[0][520], mem[0][521]}, 64'hA5_00);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h100, 32'h0, 32'h0);
    expectDone(0, 1'b0, 1'b1, 32'h0000_0513, 6);
    waitDone(0);

    // B: halfword beats with read latency 3
    s = bl_n[1];
    applyStimulus(1, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h40, 32'h0);
    expectDone(1, 1'b1, 1'b1, 32'hDEAD_BEEF, 6);
    waitDone(1);
    checkOutput("b_read_beats", 64'(bl_n[1] - s), 64'd2);
    checkOutput("b_read_addrs", {bl_addr[1][s & 255], bl_addr[1][(s + 1) & 255]}, {32'h40, 32'h42});

    // B: upper-half store, first beat has empty enables
    s = bl_n[1];
    applyStimulus(1, 1'b0, 1'b1, 1'b1, 4'b1100, 32'h0, 32'h80, 32'hCAFE_0000);
    expectDone(1, 1'b1, 1'b0, 32'h0, 3);
    waitDone(1);
    checkOutput("b_store_beats", 64'(bl_n[1] - s), 64'd1);
    checkOutput("b_store_beat", {bl_addr[1][s & 255], bl_data[1][s & 255]}, {32'h82, 32'h0000_CAFE});
    applyStimulus(1, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h80, 32'h0);
    expectDone(1, 1'b1, 1'b1, 32'hCAFE_5678, 6);
    waitDone(1);

    // B: round-robin tie after an ME grant goes to IF first
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 4'h0, 32'h80, 32'h40, 32'h0);
    expectDone(1, 1'b0, 1'b1, 32'hCAFE_5678, 6);
    expectDone(1, 1'b1, 1'b1, 32'hDEAD_BEEF, 13);
    waitDone(1);

    // B: after an IF-only grant the next tie goes to ME first
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h40, 32'h0, 32'h0);
    expectDone(1, 1'b0, 1'b1, 32'hDEAD_BEEF, 6);
    waitDone(1);
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 4'h0, 32'h40, 32'h80, 32'h0);
    expectDone(1, 1'b1, 1'b1, 32'hCAFE_5678, 6);
    expectDone(1, 1'b0, 1'b1, 32'hDEAD_BEEF, 13);
    waitDone(1);

    repeat (3) @(negedge clk);
    checkOutput("pending_expectations", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
